seq_alu: RTL

- Parametrised, registered successor to the 3-bit combinational LED arithmetic selector.
- Performs ADD, SUB, MULT, DIV and MOD on W-bit unsigned operands under a start/done handshake.
- ADD and SUB complete in one cycle. MULT uses iterative shift-add and DIV/MOD use iterative restoring division, each taking W cycles.
- Sits between switch/operand registers and the LED/display driver, which latches `result` on `done`.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_iter_core.sv | 90 +++++++++
 rtl/seq_alu.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state type for the sequential arithmetic unit.
//   OP_*    : 3-bit opcode values presented on seq_alu.op
//   state_e : controller state (IDLE / CALC / DONE)
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_MULT = 3'd2;
   localparam logic [2:0] OP_DIV  = 3'd3;
   localparam logic [2:0] OP_MOD  = 3'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_iter_core.sv
// Iterative datapath: shift-add multiply and restoring divide sharing one
// 2W accumulator, an operand register and an iteration counter.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   load_i         : capture operands, latch mode, counter <= W
//   en_i           : perform one iteration (ignored once counter is 0)
//   mul_i          : mode at load time, 1 = multiply, 0 = divide
//   a_i, b_i       : operands (multiplicand/multiplier or dividend/divisor)
//   last_c         : counter is 1, the current iteration is the final one
//   product_c      : accumulator value after this cycle's step (mul)
//   quotient_c     : low half of that value (div)
//   remainder_c    : high half of that value (div)
module alu_iter_core #(
   parameter int unsigned W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load_i,
   input  logic           en_i,
   input  logic           mul_i,
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   output logic           last_c,
   output logic [2*W-1:0] product_c,
   output logic [W-1:0]   quotient_c,
   output logic [W-1:0]   remainder_c
);

   localparam int unsigned CW = $clog2(W + 1);

   logic [2*W-1:0] acc_q, acc_d;
   logic [W-1:0]   opnd_q, opnd_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           mul_q, mul_d;
   logic [W:0]     mul_sum;
   logic [W:0]     div_shift;
   logic [W:0]     div_trial;

   // Next accumulator: load, one multiply step, or one divide step.
   always_comb begin
      acc_d  = acc_q;
      opnd_d = opnd_q;
      cnt_d  = cnt_q;
      mul_d  = mul_q;

      // Multiply: upper half plus multiplicand, carry kept for the shift.
      mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
      // Divide: partial remainder shifted left, next dividend bit brought in.
      div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
      div_trial = div_shift - {1'b0, opnd_q};

      if (load_i) begin
         mul_d  = mul_i;
         opnd_d = mul_i ? a_i : b_i;
         acc_d  = {W'(0), (mul_i ? b_i : a_i)};
         cnt_d  = CW'(W);
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
         if (mul_q) begin
            acc_d = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
         end else if (!div_trial[W]) begin
            acc_d = {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
         end else begin
            acc_d = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q  <= '0;
         opnd_q <= '0;
         cnt_q  <= '0;
         mul_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         opnd_q <= opnd_d;
         cnt_q  <= cnt_d;
         mul_q  <= mul_d;
      end
   end

   // Post-step values let the controller register the result on the same
   // edge that completes the final iteration.
   assign last_c      = (cnt_q == CW'(1));
   assign product_c   = acc_d;
   assign quotient_c  = acc_d[W-1:0];
   assign remainder_c = acc_d[2*W-1:W];

endmodule

// File: rtl/seq_alu.sv
// Registered ADD/SUB/MULT/DIV/MOD unit with a start/done handshake.
// ADD/SUB/errors finish in one cycle; MULT/DIV/MOD iterate W cycles.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : request, accepted in IDLE or DONE
//   op         : opcode (see alu_pkg), 5-7 invalid
//   a, b       : W-bit unsigned operands
//   busy       : operation iterating (CALC)
//   done       : one-cycle pulse, result/neg/err valid
//   result     : 2W-bit zero-extended result, held until next DONE
//   neg        : SUB borrow (a<b)
//   err        : divide by zero or invalid opcode
module seq_alu
   import alu_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [2:0]     op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] result,
   output logic           neg,
   output logic           err
);

   state_e         state_q, state_d;
   logic [2:0]     op_q, op_d;
   logic [2*W-1:0] result_q, result_d;
   logic           neg_q, neg_d;
   logic           err_q, err_d;
   logic           done_q, done_d;
   logic           busy_q, busy_d;

   logic           core_load, core_en, core_mul, core_last;
   logic [2*W-1:0] core_product;
   logic [W-1:0]   core_quotient, core_remainder;
   logic [W:0]     add_sum;
   logic [W-1:0]   sub_diff;

   assign add_sum  = {1'b0, a} + {1'b0, b};
   assign sub_diff = a - b;
   assign core_mul = (op == OP_MULT);

   alu_iter_core #(.W(W)) u_core (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (core_load),
      .en_i        (core_en),
      .mul_i       (core_mul),
      .a_i         (a),
      .b_i         (b),
      .last_c      (core_last),
      .product_c   (core_product),
      .quotient_c  (core_quotient),
      .remainder_c (core_remainder)
   );

   // Next-state and output-register values.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      result_d  = result_q;
      neg_d     = neg_q;
      err_d     = err_q;
      core_load = 1'b0;
      core_en   = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               op_d = op;
               case (op)
                  OP_ADD: begin
                     result_d = {(W-1)'(0), add_sum};
                     neg_d    = 1'b0;
                     err_d    = 1'b0;
                     state_d  = DONE;
                  end
                  OP_SUB: begin
                     result_d = {W'(0), sub_diff};
                     neg_d    = (a < b);
                     err_d    = 1'b0;
                     state_d  = DONE;
                  end
                  OP_MULT: begin
                     core_load = 1'b1;
                     state_d   = CALC;
                  end
                  OP_DIV, OP_MOD: begin
                     if (b == '0) begin
                        result_d = '0;
                        neg_d    = 1'b0;
                        err_d    = 1'b1;
                        state_d  = DONE;
                     end else begin
                        core_load = 1'b1;
                        state_d   = CALC;
                     end
                  end
                  default: begin
                     result_d = '0;
                     neg_d    = 1'b0;
                     err_d    = 1'b1;
                     state_d  = DONE;
                  end
               endcase
            end
         end
         CALC: begin
            core_en = 1'b1;
            if (core_last) begin
               state_d = DONE;
               neg_d   = 1'b0;
               err_d   = 1'b0;
               if (op_q == OP_MULT) begin
                  result_d = core_product;
               end else if (op_q == OP_DIV) begin
                  result_d = {W'(0), core_quotient};
               end else begin
                  result_d = {W'(0), core_remainder};
               end
            end
         end
         default: state_d = IDLE;
      endcase

      done_d = (state_d == DONE);
      busy_d = (state_d == CALC);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_q     <= '0;
         result_q <= '0;
         neg_q    <= 1'b0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         result_q <= result_d;
         neg_q    <= neg_d;
         err_q    <= err_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign neg    = neg_q;
   assign err    = err_q;

endmodule
